// File: rtl/inst_fetch.sv
// inst_fetch: PC generation and instruction fetch ahead of decode.
// Issues in-order word requests to instruction memory. Memory latency is
// absorbed by a 2-entry prefetch queue. {instruction, pc} pairs are handed
// to decode under a stall/valid handshake. Responses that were in flight
// when a redirect arrived are discarded.
//
// Ports:
//   clk, reset                    clock, asynchronous active-low reset
//   stall                         decode not accepting; head entry is held
//   redirect_valid, redirect_pc   taken branch/jump target from execute
//   inst_mem_req/ready/address    request channel to instruction memory
//   inst_mem_is_valid/read_data   in-order response channel
//   inst_valid, instruction       queue head to decode (NOP when empty)
//   inst_fetch_pc                 head PC, or last dequeued PC when empty
//   fetch_exception               sticky misaligned-redirect flag

// Protocol checker for the fetch queue and in-flight accounting.
module inst_fetch_chk (
  input logic       clk,
  input logic       reset,
  input logic       push_s,
  input logic [1:0] q_count_s,
  input logic       resp_s,
  input logic [1:0] outstanding_s
);
  // A kept response must always find room in the prefetch queue.
  assert property (@(posedge clk) disable iff (!reset) !(push_s && (q_count_s == 2'd2)));
  // Memory must never answer a request that was not issued.
  assert property (@(posedge clk) disable iff (!reset) !(resp_s && (outstanding_s == 2'd0)));
endmodule

module inst_fetch #(
  parameter logic [31:0] RESET = 32'h0000_0000,
  parameter logic [31:0] NOP   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_mem_req,
  input  logic        inst_mem_ready,
  output logic [31:0] inst_mem_address,
  input  logic        inst_mem_is_valid,
  input  logic [31:0] inst_mem_read_data,
  output logic        inst_valid,
  output logic [31:0] instruction,
  output logic [31:0] inst_fetch_pc,
  output logic        fetch_exception
);

  logic [31:0] fetch_pc_r;
  logic [31:0] q_inst_r [2];
  logic [31:0] q_pc_r [2];
  logic [1:0]  q_count_r;
  logic [31:0] if_pc_r [2];
  logic [1:0]  outstanding_r;
  logic [1:0]  discard_r;
  logic        exception_r;
  logic [31:0] last_pc_r;

  logic [2:0]  occupancy_s;
  logic        fire_s;
  logic        push_s;
  logic        pop_s;
  logic        drop_s;

  // Request credit, handshake events and decode-facing outputs.
  always_comb begin
    occupancy_s      = {1'b0, q_count_r} + {1'b0, outstanding_r};
    // Queued plus in-flight words never exceed the queue depth, so a response always fits.
    inst_mem_req     = reset && !exception_r && (occupancy_s < 3'd2) && !redirect_valid;
    inst_mem_address = fetch_pc_r;
    fire_s           = inst_mem_req && inst_mem_ready;
    drop_s           = inst_mem_is_valid && (discard_r != 2'd0);
    push_s           = inst_mem_is_valid && (discard_r == 2'd0) && !redirect_valid;
    pop_s            = (q_count_r != 2'd0) && !stall && !redirect_valid;
    inst_valid       = (q_count_r != 2'd0);
    fetch_exception  = exception_r;
    if (q_count_r != 2'd0) begin
      instruction   = q_inst_r[0];
      inst_fetch_pc = q_pc_r[0];
    end else begin
      instruction   = NOP;
      inst_fetch_pc = last_pc_r;
    end
  end

  // Fetch PC and sticky misaligned-redirect flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_r  <= RESET;
      exception_r <= 1'b0;
    end else if (redirect_valid) begin
      // Target is loaded even when misaligned so it is visible for debug.
      fetch_pc_r <= redirect_pc;
      if (redirect_pc[1:0] != 2'b00) begin
        exception_r <= 1'b1;
      end else begin
        exception_r <= exception_r;
      end
    end else if (fire_s) begin
      fetch_pc_r <= fetch_pc_r + 32'd4;
    end else begin
      fetch_pc_r <= fetch_pc_r;
    end
  end

  // In-flight request PCs, outstanding count and post-redirect discard count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_pc_r[0]    <= RESET;
      if_pc_r[1]    <= RESET;
      outstanding_r <= 2'd0;
      discard_r     <= 2'd0;
    end else begin
      case ({fire_s, inst_mem_is_valid})
        2'b10: begin
          if_pc_r[outstanding_r[0]] <= fetch_pc_r;
          outstanding_r             <= outstanding_r + 2'd1;
        end
        2'b01: begin
          if_pc_r[0]    <= if_pc_r[1];
          outstanding_r <= outstanding_r - 2'd1;
        end
        2'b11: begin
          if (outstanding_r == 2'd2) begin
            if_pc_r[0] <= if_pc_r[1];
            if_pc_r[1] <= fetch_pc_r;
          end else begin
            if_pc_r[0] <= fetch_pc_r;
          end
        end
        default: begin
          outstanding_r <= outstanding_r;
        end
      endcase
      // On redirect every word still in flight, including one landing now, is stale.
      if (redirect_valid) begin
        discard_r <= outstanding_r - {1'b0, inst_mem_is_valid};
      end else if (drop_s) begin
        discard_r <= discard_r - 2'd1;
      end else begin
        discard_r <= discard_r;
      end
    end
  end

  // Prefetch queue (entry 0 is the head) and last dequeued PC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_inst_r[0] <= NOP;
      q_inst_r[1] <= NOP;
      q_pc_r[0]   <= RESET;
      q_pc_r[1]   <= RESET;
      q_count_r   <= 2'd0;
      last_pc_r   <= RESET;
    end else begin
      if (pop_s) begin
        last_pc_r <= q_pc_r[0];
      end else begin
        last_pc_r <= last_pc_r;
      end
      if (redirect_valid) begin
        q_count_r <= 2'd0;
      end else begin
        case ({push_s, pop_s})
          2'b10: begin
            q_inst_r[q_count_r[0]] <= inst_mem_read_data;
            q_pc_r[q_count_r[0]]   <= if_pc_r[0];
            q_count_r              <= q_count_r + 2'd1;
          end
          2'b01: begin
            q_inst_r[0] <= q_inst_r[1];
            q_pc_r[0]   <= q_pc_r[1];
            q_count_r   <= q_count_r - 2'd1;
          end
          2'b11: begin
            if (q_count_r == 2'd2) begin
              q_inst_r[0] <= q_inst_r[1];
              q_pc_r[0]   <= q_pc_r[1];
              q_inst_r[1] <= inst_mem_read_data;
              q_pc_r[1]   <= if_pc_r[0];
            end else begin
              q_inst_r[0] <= inst_mem_read_data;
              q_pc_r[0]   <= if_pc_r[0];
            end
          end
          default: begin
            q_count_r <= q_count_r;
          end
        endcase
      end
    end
  end

  inst_fetch_chk u_chk (
    .clk           (clk),
    .reset         (reset),
    .push_s        (push_s),
    .q_count_s     (q_count_r),
    .resp_s        (inst_mem_is_valid),
    .outstanding_s (outstanding_r)
  );

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_W    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        inst_mem_req;
  logic        inst_mem_ready = 1'b1;
  logic [31:0] inst_mem_address;
  logic        inst_mem_is_valid = 1'b0;
  logic [31:0] inst_mem_read_data = 32'h0;
  logic        inst_valid;
  logic [31:0] instruction;
  logic [31:0] inst_fetch_pc;
  logic        fetch_exception;

  always #5 clk = ~clk;

  inst_fetch dut (
    .clk                (clk),
    .reset              (reset),
    .stall              (stall),
    .redirect_valid     (redirect_valid),
    .redirect_pc        (redirect_pc),
    .inst_mem_req       (inst_mem_req),
    .inst_mem_ready     (inst_mem_ready),
    .inst_mem_address   (inst_mem_address),
    .inst_mem_is_valid  (inst_mem_is_valid),
    .inst_mem_read_data (inst_mem_read_data),
    .inst_valid         (inst_valid),
    .instruction        (instruction),
    .inst_fetch_pc      (inst_fetch_pc),
    .fetch_exception    (fetch_exception)
  );

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } sb_t;
  typedef struct {
    int          ncyc;
    int          lat;
    int          stall_mode;   // 0 never, 1 always, 2 every third cycle
    int          rdy_mode;     // 0 always ready, 1 ready on even cycles
    logic        redir;        // redirect on the first cycle of the phase
    logic [31:0] rpc;
    logic        exp_exc;      // fetch_exception expected after the phase
    int          min_cons;     // minimum instructions decode must receive
  } phase_t;

  mreq_t       pending[$];     // memory model: accepted requests awaiting response
  sb_t         sb[$];          // scoreboard: words decode should still receive, in order
  int          cyc, lat, disc, checks, errors, consumed;
  logic        exc_m;
  logic [31:0] exp_fetch, last_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h0F0F_0000;
  endfunction

  function automatic logic resp_now();
    return (pending.size() > 0) && (pending[0].due <= cyc);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs, update the models, advance.
  task automatic cycle(input logic st, input logic rd, input logic [31:0] rpc, input logic rdy);
    logic resp, fire, cons;
    sb_t  e;
    resp               = resp_now();
    inst_mem_is_valid  = resp;
    inst_mem_read_data = resp ? mem_word(pending[0].addr) : 32'hDEAD_BEEF;
    stall              = st;
    redirect_valid     = rd;
    redirect_pc        = rpc;
    inst_mem_ready     = rdy;
    #1;
    chk("req", 32'(inst_mem_req), 32'(!exc_m && ((sb.size() + disc) < 2) && !rd));
    if (inst_mem_req) chk("addr", inst_mem_address, exp_fetch);
    if (!inst_valid) begin
      chk("nop", instruction, NOP_W);
      chk("idle_pc", inst_fetch_pc, last_pc);
    end
    fire = inst_mem_req && rdy;
    cons = inst_valid && !st && !rd;
    if (cons) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", 32'(inst_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("head_pc", inst_fetch_pc, e.pc);
        chk("head_inst", instruction, e.inst);
        last_pc = e.pc;
        consumed++;
      end
    end
    if (rd) begin
      sb.delete();
      disc      = pending.size() - (resp ? 1 : 0);
      exp_fetch = rpc;
      if (rpc[1:0] != 2'b00) exc_m = 1'b1;
    end else if (resp && (disc > 0)) begin
      disc--;
    end
    if (fire) begin
      pending.push_back('{inst_mem_address, cyc + lat});
      sb.push_back('{exp_fetch, mem_word(exp_fetch)});
      exp_fetch += 32'd4;
    end
    if (resp) void'(pending.pop_front());
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset              = 1'b0;
    stall              = 1'b0;
    redirect_valid     = 1'b0;
    redirect_pc        = 32'h0;
    inst_mem_ready     = 1'b1;
    inst_mem_is_valid  = 1'b0;
    inst_mem_read_data = 32'h0;
    pending.delete();
    sb.delete();
    disc      = 0;
    exc_m     = 1'b0;
    exp_fetch = RESET_PC;
    last_pc   = RESET_PC;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(inst_mem_req), 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", instruction, NOP_W);
    chk("rst_pc", inst_fetch_pc, RESET_PC);
    chk("rst_exc", 32'(fetch_exception), 32'd0);
    chk("rst_addr", inst_mem_address, RESET_PC);
    reset = 1'b1;
    cyc   = 0;
  endtask

  initial begin
    phase_t ph[6];
    int     c0;
    logic   st, rd, rdy;

    ph[0] = '{12, 1, 0, 0, 1'b0, 32'h0000_0000, 1'b0, 4};
    ph[1] = '{ 5, 1, 1, 0, 1'b0, 32'h0000_0000, 1'b0, 0};
    ph[2] = '{10, 1, 0, 0, 1'b0, 32'h0000_0000, 1'b0, 3};
    ph[3] = '{40, 3, 0, 1, 1'b0, 32'h0000_0000, 1'b0, 5};
    ph[4] = '{20, 2, 2, 0, 1'b1, 32'h0000_0200, 1'b0, 4};
    ph[5] = '{ 8, 1, 0, 0, 1'b1, 32'h0000_0302, 1'b1, 0};

    checks   = 0;
    errors   = 0;
    consumed = 0;
    lat      = 1;
    do_reset();

    // Table-driven phases: streaming, stall, latency 3 with ready toggling, redirects.
    for (int p = 0; p < 6; p++) begin
      c0  = consumed;
      lat = ph[p].lat;
      for (int k = 0; k < ph[p].ncyc; k++) begin
        st  = (ph[p].stall_mode == 1) || ((ph[p].stall_mode == 2) && (cyc % 3 == 0));
        rdy = (ph[p].rdy_mode == 0) || (cyc % 2 == 0);
        rd  = ph[p].redir && (k == 0);
        cycle(st, rd, ph[p].rpc, rdy);
      end
      chk("phase_exc", 32'(fetch_exception), 32'(ph[p].exp_exc));
      chk("phase_progress", 32'((consumed - c0) >= ph[p].min_cons), 32'd1);
    end

    // Reset out of the exception state clears it.
    do_reset();

    // Redirect to 0x100 with two requests outstanding (latency 3).
    lat = 3;
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1);
    cycle(1'b0, 1'b1, 32'h0000_0100, 1'b1);
    for (int k = 0; k < 12; k++) begin
      if (inst_valid) break;
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
    end
    chk("redir_valid", 32'(inst_valid), 32'd1);
    chk("redir_head_pc", inst_fetch_pc, 32'h0000_0100);
    chk("redir_head_inst", instruction, mem_word(32'h0000_0100));
    for (int k = 0; k < 10; k++) cycle(1'b0, 1'b0, 32'h0, 1'b1);
    chk("redir_progress", 32'(last_pc >= 32'h0000_0104), 32'd1);

    // Redirect coinciding with a response and a stall with a held head.
    do_reset();
    lat = 1;
    for (int k = 0; k < 10; k++) begin
      if (resp_now() && inst_valid) break;
      cycle(1'b1, 1'b0, 32'h0, 1'b1);
    end
    chk("combo_setup", 32'(resp_now() && inst_valid), 32'd1);
    cycle(1'b1, 1'b1, 32'h0000_0400, 1'b1);
    chk("combo_valid", 32'(inst_valid), 32'd0);
    chk("combo_nop", instruction, NOP_W);
    for (int k = 0; k < 12; k++) begin
      if (inst_valid) break;
      cycle(1'b0, 1'b0, 32'h0, 1'b1);
    end
    chk("combo_head_pc", inst_fetch_pc, 32'h0000_0400);
    for (int k = 0; k < 8; k++) cycle(1'b0, 1'b0, 32'h0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
